// File: rtl/bus_region_ctrl_if.sv
// Processor-side bus bundle for the 8088 region controller: strobes and address
// in from the CPU, chip selects, READY and status flags back out.
interface bus_region_ctrl_if #(
  parameter int unsigned AW          = 20,
  parameter int unsigned NUM_REGIONS = 4
);
  logic                   ALE;
  logic                   IOM;
  logic                   RD;
  logic                   WR;
  logic [AW-9:0]          A;
  logic [7:0]             AD;
  logic [AW-1:0]          Address;
  logic [NUM_REGIONS-1:0] CS;
  logic                   READY;
  logic                   DECODE_ERR;
  logic                   PROTO_ERR;
  logic                   BUS_TIMEOUT;
  logic [1:0]             BUS_STATE;

  modport master (
    output ALE, IOM, RD, WR, A, AD,
    input  Address, CS, READY, DECODE_ERR, PROTO_ERR, BUS_TIMEOUT, BUS_STATE
  );

  modport slave (
    input  ALE, IOM, RD, WR, A, AD,
    output Address, CS, READY, DECODE_ERR, PROTO_ERR, BUS_TIMEOUT, BUS_STATE
  );
endinterface

// File: rtl/bus_region_ctrl.sv
// 8088 address latch, parametrised IO/memory region decoder and per-region
// wait-state generator with decode, protocol and timeout error flags.
module bus_region_ctrl #(
  parameter int unsigned                 AW           = 20,
  parameter int unsigned                 NUM_REGIONS  = 4,
  parameter logic [NUM_REGIONS*AW-1:0]   REGION_BASE  = {20'h00000, 20'h80000, 20'h01C00, 20'h0FF00},
  parameter logic [NUM_REGIONS*AW-1:0]   REGION_LIMIT = {20'h7FFFF, 20'hFFFFF, 20'h01DFF, 20'h0FF0F},
  parameter logic [NUM_REGIONS-1:0]      REGION_IOM   = 4'b0011,
  parameter logic [NUM_REGIONS*4-1:0]    REGION_WAIT  = {4'd3, 4'd0, 4'd2, 4'd1},
  parameter int unsigned                 TIMEOUT      = 64
) (
  input logic              CLK,
  input logic              RESET,
  bus_region_ctrl_if.slave bus
);

  localparam int unsigned WW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DECODED = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_ACTIVE  = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic                   ready_q, ready_d;
  logic                   dec_err_q, dec_err_d;
  logic                   proto_q, proto_d;
  logic                   tout_q, tout_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic [WW-1:0]          wsel_q, wsel_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;

  logic [AW-1:0]          cap_addr_c;
  logic [NUM_REGIONS-1:0] dec_cs_c;
  logic [WW-1:0]          dec_wait_c;
  logic                   dec_hit_c;

  assign cap_addr_c = {bus.A, bus.AD};

  // Region decode of the address on the bus; first matching index wins.
  always_comb begin
    logic [AW-1:0] base_v;
    logic [AW-1:0] limit_v;
    logic          in_v;
    dec_cs_c   = '0;
    dec_wait_c = '0;
    dec_hit_c  = 1'b0;
    base_v     = '0;
    limit_v    = '0;
    in_v       = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      base_v  = REGION_BASE[i*AW +: AW];
      limit_v = REGION_LIMIT[i*AW +: AW];
      if (REGION_IOM[i])
        in_v = (cap_addr_c[15:0] >= base_v[15:0]) && (cap_addr_c[15:0] <= limit_v[15:0]);
      else
        in_v = (cap_addr_c >= base_v) && (cap_addr_c <= limit_v);
      if (!dec_hit_c && in_v && (REGION_IOM[i] == bus.IOM)) begin
        dec_hit_c   = 1'b1;
        dec_cs_c[i] = 1'b1;
        dec_wait_c  = REGION_WAIT[i*WW +: WW];
      end
    end
  end

  always_comb begin
    logic [TW-1:0] tcnt_inc_v;
    logic          any_v;
    logic          both_v;
    state_d   = state_q;
    addr_d    = addr_q;
    cs_d      = cs_q;
    ready_d   = ready_q;
    dec_err_d = dec_err_q;
    proto_d   = 1'b0;
    tout_d    = 1'b0;
    wcnt_d    = wcnt_q;
    wsel_d    = wsel_q;
    tcnt_d    = tcnt_q;
    any_v      = !bus.RD || !bus.WR;
    both_v     = !bus.RD && !bus.WR;
    tcnt_inc_v = (tcnt_q == TO_MAX) ? tcnt_q : TW'(tcnt_q + TW'(1));

    if (bus.ALE && (state_q == ST_IDLE || state_q == ST_DECODED)) begin
      addr_d    = cap_addr_c;
      cs_d      = dec_cs_c;
      dec_err_d = !dec_hit_c;
      wsel_d    = dec_wait_c;
      state_d   = ST_DECODED;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_DECODED: begin
          if (both_v) begin
            proto_d = 1'b1;
            cs_d    = '0;
            state_d = ST_IDLE;
          end else if (any_v) begin
            tcnt_d = '0;
            // Unmapped accesses carry wsel 0 and so never stall.
            if (wsel_q != '0) begin
              ready_d = 1'b0;
              wcnt_d  = wsel_q;
              state_d = ST_WAIT;
            end else begin
              state_d = ST_ACTIVE;
            end
          end
        end
        ST_WAIT: begin
          tcnt_d = tcnt_inc_v;
          if (tcnt_inc_v == TO_MAX) begin
            tout_d  = 1'b1;
            ready_d = 1'b1;
            cs_d    = '0;
            state_d = ST_IDLE;
          end else if (!any_v) begin
            ready_d = 1'b1;
            cs_d    = '0;
            state_d = ST_IDLE;
          end else if (wcnt_q == WW'(1)) begin
            ready_d = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            wcnt_d = wcnt_q - WW'(1);
          end
        end
        ST_ACTIVE: begin
          tcnt_d = tcnt_inc_v;
          if (tcnt_inc_v == TO_MAX) begin
            tout_d  = 1'b1;
            ready_d = 1'b1;
            cs_d    = '0;
            state_d = ST_IDLE;
          end else if (!any_v) begin
            cs_d    = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cs_q      <= '0;
      ready_q   <= 1'b1;
      dec_err_q <= 1'b0;
      proto_q   <= 1'b0;
      tout_q    <= 1'b0;
      wcnt_q    <= '0;
      wsel_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cs_q      <= cs_d;
      ready_q   <= ready_d;
      dec_err_q <= dec_err_d;
      proto_q   <= proto_d;
      tout_q    <= tout_d;
      wcnt_q    <= wcnt_d;
      wsel_q    <= wsel_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign bus.Address     = addr_q;
  assign bus.CS          = cs_q;
  assign bus.READY       = ready_q;
  assign bus.DECODE_ERR  = dec_err_q;
  assign bus.PROTO_ERR   = proto_q;
  assign bus.BUS_TIMEOUT = tout_q;
  assign bus.BUS_STATE   = state_q;

endmodule

// File: tb/tb_bus_region_ctrl.sv
// Directed bench for bus_region_ctrl: one task per scenario with hand-computed
// expectations for the default four-region map.
module tb_bus_region_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  bus_region_ctrl_if #(.AW(20), .NUM_REGIONS(4)) bus ();

  bus_region_ctrl dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic iom, input logic [19:0] addr);
    bus.ALE = 1'b1;
    bus.IOM = iom;
    bus.A   = addr[19:8];
    bus.AD  = addr[7:0];
    tick();
    bus.ALE = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    tests++;
    if (bus.Address !== 20'h0 || bus.CS !== 4'b0 || bus.READY !== 1'b1 || bus.BUS_STATE !== 2'd0) begin
      fails++;
      $display("FAIL reset_main: addr=%h cs=%b ready=%b state=%0d exp 00000/0000/1/0",
               bus.Address, bus.CS, bus.READY, bus.BUS_STATE);
    end
    tests++;
    if (bus.DECODE_ERR !== 1'b0 || bus.PROTO_ERR !== 1'b0 || bus.BUS_TIMEOUT !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: dec=%b proto=%b tout=%b exp 0/0/0",
               bus.DECODE_ERR, bus.PROTO_ERR, bus.BUS_TIMEOUT);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_io_read();
    capture(1'b1, 20'h0FF05);
    tests++;
    if (bus.CS !== 4'b0001 || bus.BUS_STATE !== 2'd1 || bus.Address !== 20'h0FF05 || bus.DECODE_ERR !== 1'b0) begin
      fails++;
      $display("FAIL io_read_decode: cs=%b state=%0d addr=%h dec=%b exp 0001/1/0ff05/0",
               bus.CS, bus.BUS_STATE, bus.Address, bus.DECODE_ERR);
    end
    bus.RD = 1'b0;
    tick();
    tests++;
    if (bus.READY !== 1'b0 || bus.BUS_STATE !== 2'd2) begin
      fails++;
      $display("FAIL io_read_wait: ready=%b state=%0d exp 0/2", bus.READY, bus.BUS_STATE);
    end
    tick();
    tests++;
    if (bus.READY !== 1'b1 || bus.BUS_STATE !== 2'd3 || bus.CS !== 4'b0001) begin
      fails++;
      $display("FAIL io_read_active: ready=%b state=%0d cs=%b exp 1/3/0001", bus.READY, bus.BUS_STATE, bus.CS);
    end
    bus.RD = 1'b1;
    tick();
    tests++;
    if (bus.CS !== 4'b0 || bus.BUS_STATE !== 2'd0 || bus.Address !== 20'h0FF05) begin
      fails++;
      $display("FAIL io_read_end: cs=%b state=%0d addr=%h exp 0000/0/0ff05", bus.CS, bus.BUS_STATE, bus.Address);
    end
  endtask

  task automatic test_mem_write();
    logic [1:0] exp_st  [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
    logic       exp_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] exp_cs  [6] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
    capture(1'b0, 20'h12345);
    for (int s = 0; s < 6; s++) begin
      tests++;
      if (bus.BUS_STATE !== exp_st[s] || bus.READY !== exp_rdy[s] || bus.CS !== exp_cs[s]) begin
        fails++;
        $display("FAIL mem_write step %0d: state=%0d ready=%b cs=%b exp %0d/%b/%b",
                 s, bus.BUS_STATE, bus.READY, bus.CS, exp_st[s], exp_rdy[s], exp_cs[s]);
      end
      if (s == 0) bus.WR = 1'b0;
      if (s == 4) bus.WR = 1'b1;
      if (s < 5) tick();
    end
  endtask

  task automatic test_mem_read_nowait();
    logic [1:0] exp_st [3] = '{2'd1, 2'd3, 2'd0};
    logic [3:0] exp_cs [3] = '{4'b0100, 4'b0100, 4'b0000};
    capture(1'b0, 20'h9ABCD);
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (bus.BUS_STATE !== exp_st[s] || bus.READY !== 1'b1 || bus.CS !== exp_cs[s]) begin
        fails++;
        $display("FAIL mem_read step %0d: state=%0d ready=%b cs=%b exp %0d/1/%b",
                 s, bus.BUS_STATE, bus.READY, bus.CS, exp_st[s], exp_cs[s]);
      end
      if (s == 0) bus.RD = 1'b0;
      if (s == 1) bus.RD = 1'b1;
      if (s < 2) tick();
    end
  endtask

  task automatic test_unmapped();
    capture(1'b1, 20'h00300);
    tests++;
    if (bus.CS !== 4'b0 || bus.DECODE_ERR !== 1'b1 || bus.BUS_STATE !== 2'd1) begin
      fails++;
      $display("FAIL unmapped_decode: cs=%b dec=%b state=%0d exp 0000/1/1", bus.CS, bus.DECODE_ERR, bus.BUS_STATE);
    end
    bus.RD = 1'b0;
    tick();
    tests++;
    if (bus.READY !== 1'b1 || bus.BUS_STATE !== 2'd3) begin
      fails++;
      $display("FAIL unmapped_nostall: ready=%b state=%0d exp 1/3", bus.READY, bus.BUS_STATE);
    end
    bus.RD = 1'b1;
    tick();
    tests++;
    if (bus.BUS_STATE !== 2'd0 || bus.DECODE_ERR !== 1'b1) begin
      fails++;
      $display("FAIL unmapped_hold: state=%0d dec=%b exp 0/1", bus.BUS_STATE, bus.DECODE_ERR);
    end
    capture(1'b1, 20'h01C10);
    tests++;
    if (bus.CS !== 4'b0010 || bus.DECODE_ERR !== 1'b0) begin
      fails++;
      $display("FAIL remap_decode: cs=%b dec=%b exp 0010/0", bus.CS, bus.DECODE_ERR);
    end
    bus.RD = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      tests++;
      if (bus.READY !== (s == 2) || bus.BUS_STATE !== ((s == 2) ? 2'd3 : 2'd2)) begin
        fails++;
        $display("FAIL remap_wait step %0d: ready=%b state=%0d", s, bus.READY, bus.BUS_STATE);
      end
    end
    bus.RD = 1'b1;
    tick();
    tests++;
    if (bus.CS !== 4'b0 || bus.BUS_STATE !== 2'd0) begin
      fails++;
      $display("FAIL remap_end: cs=%b state=%0d exp 0000/0", bus.CS, bus.BUS_STATE);
    end
  endtask

  task automatic test_recapture();
    bus.ALE = 1'b1;
    bus.IOM = 1'b1;
    {bus.A, bus.AD} = 20'h0FF05;
    tick();
    {bus.A, bus.AD} = 20'h01C10;
    tick();
    tests++;
    if (bus.CS !== 4'b0010 || bus.Address !== 20'h01C10 || bus.BUS_STATE !== 2'd1) begin
      fails++;
      $display("FAIL recapture: cs=%b addr=%h state=%0d exp 0010/01c10/1", bus.CS, bus.Address, bus.BUS_STATE);
    end
    bus.ALE = 1'b0;
    bus.RD  = 1'b0;
    tick();
    bus.ALE = 1'b1;
    bus.IOM = 1'b0;
    {bus.A, bus.AD} = 20'h9ABCD;
    tick();
    tests++;
    if (bus.Address !== 20'h01C10 || bus.CS !== 4'b0010 || bus.BUS_STATE !== 2'd2) begin
      fails++;
      $display("FAIL ale_in_wait: addr=%h cs=%b state=%0d exp 01c10/0010/2", bus.Address, bus.CS, bus.BUS_STATE);
    end
    bus.ALE = 1'b0;
    tick();
    bus.RD = 1'b1;
    tick();
    tests++;
    if (bus.BUS_STATE !== 2'd0 || bus.READY !== 1'b1) begin
      fails++;
      $display("FAIL recapture_end: state=%0d ready=%b exp 0/1", bus.BUS_STATE, bus.READY);
    end
  endtask

  task automatic test_proto_err();
    capture(1'b1, 20'h0FF05);
    bus.RD = 1'b0;
    bus.WR = 1'b0;
    tick();
    tests++;
    if (bus.PROTO_ERR !== 1'b1 || bus.CS !== 4'b0 || bus.BUS_STATE !== 2'd0 || bus.READY !== 1'b1) begin
      fails++;
      $display("FAIL proto_pulse: proto=%b cs=%b state=%0d ready=%b exp 1/0000/0/1",
               bus.PROTO_ERR, bus.CS, bus.BUS_STATE, bus.READY);
    end
    bus.RD = 1'b1;
    bus.WR = 1'b1;
    tick();
    tests++;
    if (bus.PROTO_ERR !== 1'b0) begin
      fails++;
      $display("FAIL proto_one_clock: proto=%b exp 0", bus.PROTO_ERR);
    end
  endtask

  task automatic test_timeout();
    int         first = 0;
    int         pulses = 0;
    logic       rdy_at = 1'bx;
    logic [1:0] st_at = 2'bxx;
    logic [3:0] cs_at = 4'bxxxx;
    logic [1:0] st64 = 2'bxx;
    capture(1'b0, 20'h00010);
    bus.RD = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (c == 64) st64 = bus.BUS_STATE;
      if (bus.BUS_TIMEOUT === 1'b1) begin
        pulses++;
        if (first == 0) begin
          first  = c;
          rdy_at = bus.READY;
          st_at  = bus.BUS_STATE;
          cs_at  = bus.CS;
        end
      end
    end
    bus.RD = 1'b1;
    tests++;
    if (first != 65 || pulses != 1) begin
      fails++;
      $display("FAIL timeout_pulse: first=%0d pulses=%0d exp 65/1", first, pulses);
    end
    tests++;
    if (rdy_at !== 1'b1 || st_at !== 2'd0 || cs_at !== 4'b0 || st64 !== 2'd3) begin
      fails++;
      $display("FAIL timeout_state: ready=%b state=%0d cs=%b st64=%0d exp 1/0/0000/3", rdy_at, st_at, cs_at, st64);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    capture(1'b0, 20'h12345);
    bus.WR = 1'b0;
    tick();
    tests++;
    if (bus.READY !== 1'b0 || bus.BUS_STATE !== 2'd2) begin
      fails++;
      $display("FAIL pre_reset_wait: ready=%b state=%0d exp 0/2", bus.READY, bus.BUS_STATE);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.READY !== 1'b1 || bus.CS !== 4'b0 || bus.BUS_STATE !== 2'd0 || bus.Address !== 20'h0) begin
      fails++;
      $display("FAIL async_reset: ready=%b cs=%b state=%0d addr=%h exp 1/0000/0/00000",
               bus.READY, bus.CS, bus.BUS_STATE, bus.Address);
    end
    bus.WR = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    bus.ALE = 1'b0;
    bus.IOM = 1'b0;
    bus.RD  = 1'b1;
    bus.WR  = 1'b1;
    bus.A   = '0;
    bus.AD  = '0;
    test_reset();
    test_io_read();
    test_mem_write();
    test_mem_read_nowait();
    test_unmapped();
    test_recapture();
    test_proto_err();
    test_timeout();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_region_ctrl.md
Name: bus_region_ctrl

Overview:
- Parametrised 8088-style bus address latch, region decoder and wait-state generator; next generation of the fixed 4-way IO/memory chip-select logic.
- Sits between the Intel8088 bus-functional model and N memory/IO slaves.
- Captures {A,AD} on ALE and decodes it against NUM_REGIONS parameter-defined IO or memory windows.
- Drives one-hot chip selects, inserts per-region wait states on READY, and flags unmapped accesses, protocol errors and bus timeouts.

Parameters:
- AW, 20, latched address width (≥16)
- NUM_REGIONS, 4, number of decode windows
- REGION_BASE, {20'h00000,20'h80000,20'h01C00,20'h0FF00}, packed NUM_REGIONS*AW inclusive lower bounds; region 0 in LSBs
- REGION_LIMIT, {20'h7FFFF,20'hFFFFF,20'h01DFF,20'h0FF0F}, packed inclusive upper bounds
- REGION_IOM, 4'b0011, per-region space: 1=IO, 0=memory
- REGION_WAIT, {4'd3,4'd0,4'd2,4'd1}, packed 4-bit wait-state count per region
- TIMEOUT, 64, max clocks a strobe may stay active in WAIT/ACTIVE

Ports:
- CLK  input  1  bus clock, all state updates on rising edge
- RESET  input  1  asynchronous, active-high reset
- ALE  input  1  address latch enable from processor
- IOM  input  1  1=IO cycle, 0=memory cycle
- RD  input  1  read strobe, active low
- WR  input  1  write strobe, active low
- A  input  AW-8  upper address bits
- AD  input  8  multiplexed low address/data byte (address sampled only)
- Address  output  AW  latched bus address
- CS  output  NUM_REGIONS  one-hot chip selects, active high
- READY  output  1  to processor; low inserts wait states
- DECODE_ERR  output  1  latched address matched no region
- PROTO_ERR  output  1  one-clock pulse: RD and WR both low
- BUS_TIMEOUT  output  1  one-clock pulse: strobe exceeded TIMEOUT
- BUS_STATE  output  2  debug: 0=IDLE, 1=DECODED, 2=WAIT, 3=ACTIVE

Behaviour:
- Reset (async, any state, mid-cycle included): Address=0, CS=0, READY=1, DECODE_ERR=0, PROTO_ERR=0, BUS_TIMEOUT=0, state IDLE, counters 0.
- Capture: on a rising edge with ALE=1 in IDLE or DECODED:
  - Address<={A,AD}; latched IOM stored.
  - CS and DECODE_ERR registered on the same edge from {A,AD} and IOM (latency 1 clock from ALE sample).
  - State goes to DECODED.
  - ALE held high for several clocks recaptures each clock.
  - ALE in WAIT/ACTIVE is ignored.
- Match rule: region i matches when REGION_IOM[i]==IOM and BASE≤addr≤LIMIT.
  - IO regions compare Address[15:0] only, bounds truncated to 16 bits.
  - Memory regions compare the full AW bits.
  - Overlapping matches: lowest index wins, so CS is strictly one-hot.
  - No match: CS=0, DECODE_ERR=1, held until the next capture or reset.
- DECODED:
  - Exactly one of RD/WR sampled low with selected region wait W>0: READY<=0, wait counter<=W, go WAIT.
  - W=0, or unmapped: READY stays 1, go ACTIVE. Unmapped accesses never stall.
  - RD and WR both low: PROTO_ERR pulses 1 clock, CS<=0, go IDLE.
- WAIT:
  - READY low for exactly W rising edges after strobe detection.
  - Counter decrements each clock; at counter==1, READY<=1 and go ACTIVE.
  - Strobe released early (both high): READY<=1, CS<=0, go IDLE.
- ACTIVE: RD and WR both high sampled: CS<=0, go IDLE. Address holds its value.
- Timeout:
  - Counter clears on entry to WAIT/ACTIVE and increments each clock in WAIT or ACTIVE.
  - When it reaches TIMEOUT: BUS_TIMEOUT pulses 1 clock, READY<=1, CS<=0, go IDLE.
  - In IDLE, strobes are ignored; only ALE leaves IDLE.
- Counter widths:
  - Wait counter: 4 bits.
  - Timeout counter: $clog2(TIMEOUT+1) bits, saturating, no wrap.

Test Plan:
- Reset mid-WAIT: assert RESET while READY=0 -> READY=1, CS=0, BUS_STATE=0 immediately, without waiting for a clock edge.
- IO read of 0xFF05: ALE, IOM=1, then RD low -> CS=4'b0001 one clock after ALE; READY low exactly 1 clock; CS clears the clock after RD high.
- Memory write of 0x12345: IOM=0, then WR low -> CS=4'b1000; READY low 3 clocks; then ACTIVE; BUS_STATE sequence 1,2,2,2,3,0.
- Memory read of 0x9ABCD -> CS=4'b0100; READY never drops; BUS_STATE 1,3,0.
- Unmapped IO 0x0300 -> CS=0, DECODE_ERR=1, READY stays 1; next capture of 0x1C10 clears DECODE_ERR and gives CS=4'b0010 with 2 wait states.
- Error cases:
  - RD and WR both low in DECODED -> PROTO_ERR one-clock pulse, CS=0.
  - RD held low 100 clocks on region 3 -> BUS_TIMEOUT pulse on the 64th WAIT/ACTIVE clock, READY=1, BUS_STATE=0.
